// File: rtl/hangman_pkg.sv
// Shared definitions for the hangman game controller.
// Contents: FSM state enum, default parameter values, letter-code constants
// (A=0 .. Z=25) and a saturating-increment helper used for the player scores.
package hangman_pkg;

  typedef enum logic [2:0] {
    S_LOAD, S_READY, S_PLAY, S_CHECK, S_WIN, S_LOSE_PARTS, S_LOSE_TIME
  } state_t;

  localparam int DEF_MAX_LEN    = 16;
  localparam int DEF_CHAR_W     = 5;
  localparam int DEF_MAX_MISS   = 10;
  localparam int DEF_TIME_LIMIT = 60;
  localparam int DEF_SCORE_W    = 4;

  localparam logic [4:0] CH_A = 5'd0;
  localparam logic [4:0] CH_C = 5'd2;
  localparam logic [4:0] CH_T = 5'd19;
  localparam logic [4:0] CH_Z = 5'd25;

  // Increment v, holding once it reaches vmax.
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] vmax);
    return (v >= vmax) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hangman_game_ctrl_if.sv
// Bus between the keyboard decoder / drawing datapath (master) and the
// hangman controller (slave).
// master drives: load_char, char_in, end_input, start, try_valid, guess, wipe, tick
// slave drives:  word_len, revealed, misses, time_left, guess_ready, hit, miss,
//                win, lose_parts, lose_time, p1_score, p2_score
//                (+ dup_guess when HANGMAN_GUESS_LOG_EN is defined)
interface hangman_game_ctrl_if
  import hangman_pkg::*;
#(
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int CHAR_W     = DEF_CHAR_W,
  parameter int MAX_MISS   = DEF_MAX_MISS,
  parameter int TIME_LIMIT = DEF_TIME_LIMIT,
  parameter int SCORE_W    = DEF_SCORE_W
);
  logic                              load_char;
  logic [CHAR_W-1:0]                 char_in;
  logic                              end_input;
  logic                              start;
  logic                              try_valid;
  logic [CHAR_W-1:0]                 guess;
  logic                              wipe;
  logic                              tick;
  logic [$clog2(MAX_LEN+1)-1:0]      word_len;
  logic [MAX_LEN-1:0]                revealed;
  logic [$clog2(MAX_MISS+1)-1:0]     misses;
  logic [$clog2(TIME_LIMIT+1)-1:0]   time_left;
  logic                              guess_ready;
  logic                              hit;
  logic                              miss;
  logic                              win;
  logic                              lose_parts;
  logic                              lose_time;
  logic [SCORE_W-1:0]                p1_score;
  logic [SCORE_W-1:0]                p2_score;
`ifdef HANGMAN_GUESS_LOG_EN
  logic                              dup_guess;
`endif

  modport master (
    output load_char, char_in, end_input, start, try_valid, guess, wipe, tick,
    input  word_len, revealed, misses, time_left, guess_ready, hit, miss,
           win, lose_parts, lose_time, p1_score, p2_score
`ifdef HANGMAN_GUESS_LOG_EN
           , dup_guess
`endif
  );

  modport slave (
    input  load_char, char_in, end_input, start, try_valid, guess, wipe, tick,
    output word_len, revealed, misses, time_left, guess_ready, hit, miss,
           win, lose_parts, lose_time, p1_score, p2_score
`ifdef HANGMAN_GUESS_LOG_EN
           , dup_guess
`endif
  );
endinterface

// File: rtl/hangman_timer.sv
// Game countdown: loads TIME_LIMIT, decrements on each tick, holds at zero.
// Ports: clk, resetn (async low), load (reload TIME_LIMIT), clear (force 0),
//        tick (decrement enable), time_left, expired (time_left == 0).
module hangman_timer #(
  parameter int TIME_LIMIT = 60
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              load,
  input  logic                              clear,
  input  logic                              tick,
  output logic [$clog2(TIME_LIMIT+1)-1:0]   time_left,
  output logic                              expired
);
  localparam int TW = $clog2(TIME_LIMIT+1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                       time_left <= '0;
    else if (clear)                    time_left <= '0;
    else if (load)                     time_left <= TW'(TIME_LIMIT);
    else if (tick && time_left != '0)  time_left <= time_left - TW'(1);
  end

  assign expired = (time_left == '0);
endmodule

// File: rtl/hangman_game_ctrl.sv
// Hangman game controller: word register file, parallel guess comparator,
// game FSM and saturating per-player scores. Countdown lives in hangman_timer.
// Ports: clk, resetn (async low), bus (hangman_game_ctrl_if.slave) carrying
//        the keyboard strobes/letters in and the game status out.
// Optional feature: define HANGMAN_GUESS_LOG_EN to keep a used-letter bitmap;
// repeated guesses are then dropped in PLAY and flagged on bus.dup_guess.
module hangman_game_ctrl
  import hangman_pkg::*;
#(
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int CHAR_W     = DEF_CHAR_W,
  parameter int MAX_MISS   = DEF_MAX_MISS,
  parameter int TIME_LIMIT = DEF_TIME_LIMIT,
  parameter int SCORE_W    = DEF_SCORE_W
) (
  input  logic               clk,
  input  logic               resetn,
  hangman_game_ctrl_if.slave bus
);
  localparam int LW   = $clog2(MAX_LEN+1);
  localparam int MW   = $clog2(MAX_MISS+1);
  localparam int TW   = $clog2(TIME_LIMIT+1);
  localparam int SMAX = (1 << SCORE_W) - 1;

  state_t                         state, state_nx;
  logic [MAX_LEN-1:0][CHAR_W-1:0] word;
  logic [LW-1:0]                  word_len;
  logic [MAX_LEN-1:0]             revealed, mask, len_mask, rev_nx;
  logic [MW-1:0]                  misses, miss_nx;
  logic [CHAR_W-1:0]              guess_q;
  logic                           hit, miss;
  logic [SCORE_W-1:0]             p1_score, p2_score;
  logic [TW-1:0]                  time_left;
  logic                           expired;
  logic                           load_ok, play_try, accept, is_dup, wipe_go, end_state;

  assign end_state = (state == S_WIN) || (state == S_LOSE_PARTS) || (state == S_LOSE_TIME);
  assign wipe_go   = end_state && bus.wipe;
  assign load_ok   = (state == S_LOAD) && bus.load_char && (word_len < LW'(MAX_LEN));
  // Timeout wins over a guess arriving in the same cycle.
  assign play_try  = (state == S_PLAY) && !expired && bus.try_valid;
  assign accept    = play_try && !is_dup;

`ifdef HANGMAN_GUESS_LOG_EN
  logic [(1<<CHAR_W)-1:0] used;
  logic                   dup_guess;
  assign is_dup        = used[bus.guess];
  assign bus.dup_guess = dup_guess;
`else
  assign is_dup = 1'b0;
`endif

  // Compare the latched guess against every stored letter at once; only
  // positions inside the loaded word may match.
  always_comb begin
    mask     = '0;
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(word_len));
      mask[i]     = len_mask[i] && (word[i] == guess_q);
    end
    rev_nx  = revealed | mask;
    miss_nx = (mask == '0) ? misses + MW'(1) : misses;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_LOAD;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      // load_ok covers a char arriving with end_input into an empty word.
      S_LOAD:  if (bus.end_input && (word_len != '0 || load_ok)) state_nx = S_READY;
      S_READY: if (bus.start) state_nx = S_PLAY;
      S_PLAY:  if (expired) state_nx = S_LOSE_TIME;
               else if (accept) state_nx = S_CHECK;
      S_CHECK: if (rev_nx == len_mask) state_nx = S_WIN;
               else if (miss_nx == MW'(MAX_MISS)) state_nx = S_LOSE_PARTS;
               else state_nx = S_PLAY;
      default: if (bus.wipe) state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      word     <= '0;
      word_len <= '0;
      revealed <= '0;
      misses   <= '0;
      guess_q  <= '0;
      hit      <= 1'b0;
      miss     <= 1'b0;
      p1_score <= '0;
      p2_score <= '0;
`ifdef HANGMAN_GUESS_LOG_EN
      used      <= '0;
      dup_guess <= 1'b0;
`endif
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++)
        if (load_ok && int'(word_len) == i) word[i] <= bus.char_in;
      if (load_ok) word_len <= word_len + LW'(1);
      if (accept)  guess_q  <= bus.guess;
`ifdef HANGMAN_GUESS_LOG_EN
      dup_guess <= play_try && is_dup;
      if (accept) used[bus.guess] <= 1'b1;
`endif
      if (state == S_CHECK) begin
        revealed <= rev_nx;
        misses   <= miss_nx;
        hit      <= (mask != '0);
        miss     <= (mask == '0);
      end
      // End states are only reachable from PLAY/CHECK, so a state change
      // into one of them is exactly the entry event.
      if (state_nx != state) begin
        if (state_nx == S_WIN)
          p2_score <= SCORE_W'(sat_inc(16'(p2_score), 16'(SMAX)));
        if (state_nx == S_LOSE_PARTS || state_nx == S_LOSE_TIME)
          p1_score <= SCORE_W'(sat_inc(16'(p1_score), 16'(SMAX)));
      end
      if (wipe_go) begin
        word     <= '0;
        word_len <= '0;
        revealed <= '0;
        misses   <= '0;
`ifdef HANGMAN_GUESS_LOG_EN
        used     <= '0;
`endif
      end
    end
  end

  hangman_timer #(.TIME_LIMIT(TIME_LIMIT)) u_timer (
    .clk       (clk),
    .resetn    (resetn),
    .load      ((state == S_READY) && bus.start),
    .clear     (wipe_go),
    .tick      (bus.tick && (state == S_PLAY || state == S_CHECK)),
    .time_left (time_left),
    .expired   (expired)
  );

  assign bus.word_len    = word_len;
  assign bus.revealed    = revealed;
  assign bus.misses      = misses;
  assign bus.time_left   = time_left;
  assign bus.guess_ready = (state == S_PLAY);
  assign bus.hit         = hit;
  assign bus.miss        = miss;
  assign bus.win         = (state == S_WIN);
  assign bus.lose_parts  = (state == S_LOSE_PARTS);
  assign bus.lose_time   = (state == S_LOSE_TIME);
  assign bus.p1_score    = p1_score;
  assign bus.p2_score    = p2_score;
endmodule

// File: tb/tb_hangman_game_ctrl.sv
// Bench for hangman_game_ctrl: directed game scenarios plus random games,
// checked against a word/guess-level reference model held in the bench.
module tb_hangman_game_ctrl;
  import hangman_pkg::*;

  localparam int MAX_LEN    = 16;
  localparam int CHAR_W     = 5;
  localparam int MAX_MISS   = 10;
  localparam int TIME_LIMIT = 3;
  localparam int SCORE_W    = 4;
  localparam int SCORE_MAX  = (1 << SCORE_W) - 1;

  logic clk;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  // Reference model: the word as a list of letters, revealed positions,
  // miss count, remaining time, scores and the game outcome (0 = running).
  int          m_word[$];
  logic [15:0] m_rev;
  int          m_misses, m_time, m_p1, m_p2, m_over;
`ifdef HANGMAN_GUESS_LOG_EN
  logic [31:0] m_used;
`endif

  hangman_game_ctrl_if #(.MAX_LEN(MAX_LEN), .CHAR_W(CHAR_W), .MAX_MISS(MAX_MISS),
                         .TIME_LIMIT(TIME_LIMIT), .SCORE_W(SCORE_W)) bus ();

  hangman_game_ctrl #(.MAX_LEN(MAX_LEN), .CHAR_W(CHAR_W), .MAX_MISS(MAX_MISS),
                      .TIME_LIMIT(TIME_LIMIT), .SCORE_W(SCORE_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v < SCORE_MAX) ? v + 1 : SCORE_MAX;
  endfunction

  task automatic model_clear_round();
    m_word.delete();
    m_rev = '0; m_misses = 0; m_time = 0; m_over = 0;
`ifdef HANGMAN_GUESS_LOG_EN
    m_used = '0;
`endif
  endtask

  task automatic load_one(input int c, input bit with_end);
    bus.load_char = 1'b1; bus.char_in = CHAR_W'(c); bus.end_input = with_end;
    @(negedge clk);
    bus.load_char = 1'b0; bus.end_input = 1'b0;
    if (m_word.size() < MAX_LEN) m_word.push_back(c);
  endtask

  task automatic end_word();
    bus.end_input = 1'b1;
    @(negedge clk);
    bus.end_input = 1'b0;
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    m_time = TIME_LIMIT;
    chk("start_time", bus.time_left, m_time);
    chk("start_ready", bus.guess_ready, 1);
  endtask

  task automatic tick1();
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    if (m_time > 0) m_time--;
    chk("tick_time", bus.time_left, m_time);
  endtask

  task automatic wipe_round();
    bus.wipe = 1'b1;
    @(negedge clk);
    bus.wipe = 1'b0;
    model_clear_round();
    chk("wipe_state", {bus.word_len, bus.revealed, bus.misses, bus.time_left}, 0);
    chk("wipe_levels", {bus.win, bus.lose_parts, bus.lose_time, bus.guess_ready}, 0);
    chk("wipe_scores", {bus.p1_score, bus.p2_score}, {m_p1[SCORE_W-1:0], m_p2[SCORE_W-1:0]});
  endtask

  task automatic do_guess(input int g);
    logic [15:0] m, full;
    bit          h;
    bus.try_valid = 1'b1; bus.guess = CHAR_W'(g);
    @(negedge clk);
    bus.try_valid = 1'b0;
    if (m_time == 0) begin
      m_p1 = sat(m_p1); m_over = 3;
      chk("lose_time", bus.lose_time, 1);
      chk("time_ready", bus.guess_ready, 0);
      chk("time_p1", bus.p1_score, m_p1);
      @(negedge clk);
      chk("time_nohit", {bus.hit, bus.miss}, 0);
      chk("time_rev", bus.revealed, m_rev);
      return;
    end
`ifdef HANGMAN_GUESS_LOG_EN
    if (m_used[g]) begin
      chk("dup_pulse", bus.dup_guess, 1);
      chk("dup_ready", bus.guess_ready, 1);
      @(negedge clk);
      chk("dup_nohit", {bus.hit, bus.miss, bus.dup_guess}, 0);
      chk("dup_misses", bus.misses, m_misses);
      return;
    end
    m_used[g] = 1'b1;
`endif
    chk("check_ready", bus.guess_ready, 0);
    @(negedge clk);
    m = '0;
    foreach (m_word[i]) if (m_word[i] == g) m[i] = 1'b1;
    h = (m != '0);
    if (!h) m_misses++;
    m_rev = m_rev | m;
    full = 16'((32'h1 << m_word.size()) - 1);
    if (m_rev == full) begin m_over = 1; m_p2 = sat(m_p2); end
    else if (m_misses == MAX_MISS) begin m_over = 2; m_p1 = sat(m_p1); end
    chk("hit", bus.hit, h);
    chk("miss", bus.miss, !h);
    chk("revealed", bus.revealed, m_rev);
    chk("misses", bus.misses, m_misses);
    chk("win", bus.win, m_over == 1);
    chk("lose_parts", bus.lose_parts, m_over == 2);
    chk("ready_after", bus.guess_ready, m_over == 0);
    chk("scores", {bus.p1_score, bus.p2_score}, {m_p1[SCORE_W-1:0], m_p2[SCORE_W-1:0]});
  endtask

  task automatic load_cat(input bit together);
    load_one(CH_C, 1'b0);
    load_one(CH_A, 1'b0);
    load_one(CH_T, together);
    if (!together) end_word();
    chk("cat_len", bus.word_len, 3);
  endtask

  task automatic random_game(input int n);
    int  k = 0;
    bit  e;
    for (int i = 0; i < n; i++) begin
      e = (i == n - 1) && ($urandom_range(1) == 1);
      load_one($urandom_range(7), e);
      if (i == n - 1 && !e) end_word();
    end
    chk("rnd_len", bus.word_len, m_word.size());
    start_game();
    while (m_over == 0 && k < 300) begin
      if ($urandom_range(3) == 0) tick1();
      do_guess($urandom_range(7));
      k++;
    end
    chk("rnd_ends", m_over != 0, 1);
    wipe_round();
  endtask

  task automatic quick_loss();
    load_one($urandom_range(25), 1'b1);
    start_game();
    for (int i = 0; i < TIME_LIMIT; i++) tick1();
    do_guess(0);
    wipe_round();
  endtask

  initial begin
    resetn = 1'b0;
    bus.load_char = 1'b0; bus.char_in = '0; bus.end_input = 1'b0; bus.start = 1'b0;
    bus.try_valid = 1'b0; bus.guess = '0; bus.wipe = 1'b0; bus.tick = 1'b0;
    m_p1 = 0; m_p2 = 0;
    model_clear_round();
    @(negedge clk); @(negedge clk);
    chk("rst_state", {bus.word_len, bus.revealed, bus.misses, bus.time_left}, 0);
    chk("rst_flags", {bus.guess_ready, bus.hit, bus.miss, bus.win, bus.lose_parts, bus.lose_time}, 0);
    chk("rst_scores", {bus.p1_score, bus.p2_score}, 0);
`ifdef HANGMAN_GUESS_LOG_EN
    chk("rst_dup", bus.dup_guess, 0);
`endif
    resetn = 1'b1;
    @(negedge clk);

    // Empty word: end_input and start are both ignored.
    end_word();
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    chk("empty_ready", bus.guess_ready, 0);
    chk("empty_time", bus.time_left, 0);

    // CAT: reveal A, then ten distinct wrong letters complete the gallows.
    load_cat(1'b0);
    start_game();
    do_guess(CH_A);
    chk("cat_rev_a", bus.revealed, 16'h0002);
    for (int i = 0; i < MAX_MISS; i++) do_guess(3 + i);
    chk("parts_misses", bus.misses, MAX_MISS);
    chk("parts_p1", bus.p1_score, 1);
    wipe_round();
    chk("p1_kept", bus.p1_score, 1);

    // CAT again, last letter loaded together with end_input; Z twice, then win.
    load_cat(1'b1);
    start_game();
    do_guess(CH_Z);
    do_guess(CH_Z);
`ifdef HANGMAN_GUESS_LOG_EN
    chk("dup_z_misses", bus.misses, 1);
`else
    chk("rep_z_misses", bus.misses, 2);
`endif
    do_guess(CH_C);
    do_guess(CH_A);
    do_guess(CH_A);
    do_guess(CH_T);
    chk("win_level", bus.win, 1);
    chk("win_rev", bus.revealed, 16'h0007);
    chk("win_p2", bus.p2_score, 1);
    wipe_round();

    // Timeout beats a guess in the cycle time_left reaches 0.
    load_cat(1'b0);
    start_game();
    for (int i = 0; i < TIME_LIMIT; i++) tick1();
    chk("to_zero", bus.time_left, 0);
    do_guess(CH_A);
    chk("to_p1", bus.p1_score, 2);
    wipe_round();

    // Overlong word is clipped, then played out.
    for (int i = 0; i < MAX_LEN + 1; i++) load_one($urandom_range(7), 1'b0);
    end_word();
    chk("clip_len", bus.word_len, MAX_LEN);
    start_game();
    begin
      int k = 0;
      while (m_over == 0 && k < 300) begin
        if ($urandom_range(3) == 0) tick1();
        do_guess($urandom_range(7));
        k++;
      end
      chk("clip_ends", m_over != 0, 1);
    end
    wipe_round();

    for (int g = 0; g < 8; g++) random_game(1 + $urandom_range(MAX_LEN - 1));

    // Drive p1 to saturation, then one more loss.
    begin
      int k = 0;
      while (m_p1 < SCORE_MAX && k < 40) begin quick_loss(); k++; end
    end
    quick_loss();
    chk("p1_sat", bus.p1_score, SCORE_MAX);

    // Reset in the middle of a game clears everything including scores.
    load_cat(1'b0);
    start_game();
    do_guess(CH_C);
    resetn = 1'b0;
    #1;
    chk("midrst_state", {bus.word_len, bus.revealed, bus.misses, bus.time_left}, 0);
    chk("midrst_flags", {bus.guess_ready, bus.win, bus.lose_parts, bus.lose_time}, 0);
    chk("midrst_scores", {bus.p1_score, bus.p2_score}, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
